lc3_fetch_ctrl: RTL
===================

# lc3_fetch_ctrl

Parametrised LC-3 fetch/redirect controller: on each `fetch_start` pulse it resolves the next PC from the retiring instruction's opcode, branch condition and operands. For load/store opcodes it first drives one data-memory access, then drives the instruction fetch on the shared memory port, waiting a configurable memory latency. It sits between the decode/execute stage and the single-port unified memory, and succeeds the fixed-width, fixed-latency fetch unit.

## Interface
- `ADDR_W`, 16, address/PC/register width.
- `OFFSET_W`, 9, width of `offset_in`; must satisfy `OFFSET_W <= ADDR_W`.
- `MEM_LAT`, 1, memory access latency in cycles, ≥1.
- `RESET_PC`, 0, PC value loaded by reset.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `fetch_start`  in  1  one-cycle request: retire current instruction, advance PC.
- `opCode_in`  in  4  opcode of retiring instruction.
- `offset_in`  in  OFFSET_W  signed offset, already sign-extended by decode to OFFSET_W.
- `reg_in`  in  ADDR_W  base register value (JMP/LDR/STR).
- `br_nzp`  in  3  BR condition mask.
- `result_nzp`  in  3  current condition codes.
- `addr_out`  out  ADDR_W  memory address (registered).
- `wea_out`  out  1  memory write enable (registered).
- `pc`  out  ADDR_W  address of the current instruction.
- `busy`  out  1  high whenever state ≠ IDLE.
- `ir_valid`  out  1  one-cycle pulse: fetched instruction is on the memory read bus.

## Operation
- States: IDLE, MEM, FETCH.
- IDLE: `addr_out`=0, `wea_out`=0. Samples `fetch_start`. All inputs are captured in the same cycle.
- The captured start goes to MEM for LD(0010), ST(0011), LDR(0110) and STR(0111). It goes to FETCH for every other opcode.
- `fetch_start` while `busy`=1: ignored, not queued.
- `sext` = sign-extend `offset_in` to ADDR_W. `pc_inc` = `pc`+1. All sums are modulo 2^ADDR_W (wrap, no flag).
- Next PC:
  - BR(0000): `pc_inc`+`sext` if `|(br_nzp & result_nzp)`; `br_nzp`=000 is never taken. Otherwise `pc_inc`.
  - JSR(0100): `pc_inc`+`sext`.
  - JMP(1100): `reg_in`.
  - All others: `pc_inc`.
- Effective address:
  - LD/ST: `pc_inc`+`sext`.
  - LDR/STR: `reg_in`+`sext`.
- MEM: `addr_out`=EA for MEM_LAT cycles. `wea_out`=1 in the first MEM cycle only, and only for ST/STR. Then go to FETCH.
- FETCH: `pc` loads next PC on entry. `addr_out`=next PC for MEM_LAT cycles. Then return to IDLE with `ir_valid`=1 for that one cycle.
- `rst_n`=0 overrides everything, including a concurrent `fetch_start`, and aborts any access. A write in progress is dropped.

## Timing
- Reset values (next edge after `rst_n`=0): state IDLE, `pc`=RESET_PC, `addr_out`=0, `wea_out`=0, `busy`=0, `ir_valid`=0.
- Non-memory op, start sampled at edge T:
  - T+1: FETCH, `pc` and `addr_out` = next PC.
  - T+1..T+MEM_LAT: FETCH.
  - T+MEM_LAT+1: IDLE, `ir_valid`=1.
- Memory op, start sampled at edge T:
  - T+1..T+MEM_LAT: MEM. `wea_out` is high at T+1 only, for stores.
  - T+MEM_LAT+1: `pc` updates.
  - T+MEM_LAT+1..T+2·MEM_LAT: FETCH.
  - T+2·MEM_LAT+1: `ir_valid`=1.
- A start is accepted in the same cycle `ir_valid` is high (back-to-back).
- `pc` changes only on FETCH entry or reset.

## Structure
- `lc3_pkg`: opcode localparams (BR, LD, ST, JSR, LDR, STR, JMP) and the state enum; shared with decode.
- Sub-module `lc3_next_pc`: combinational next-PC/EA computation (sign-extend, adders, BR condition). Parametrised by ADDR_W/OFFSET_W.
- Top: FSM, latency counter (`$clog2(MEM_LAT+1)` bits), captured-input registers, output registers.

## Test plan
(ADDR_W=16, OFFSET_W=9, MEM_LAT=2, RESET_PC=0 unless stated.)
- Hold reset 5 cycles, release, no `fetch_start` -> `addr_out`=0, `wea_out`=0, `pc`=0, `busy`=0, `ir_valid`=0 for 10 cycles.
- ADD(0001) start at `pc`=0x0000 -> `pc`=0x0001 and `addr_out`=0x0001 at T+1 and T+2. `ir_valid` at T+3, `addr_out`=0 at T+3.
- BR at `pc`=0x0010, `br_nzp`=010, `result_nzp`=010, `offset_in`=9'h1FD -> `pc`=0x000E. Same with `result_nzp`=100 -> `pc`=0x0011. `br_nzp`=000 -> 0x0011.
- STR at `pc`=0x0020, `reg_in`=0x3000, `offset_in`=5 -> `addr_out`=0x3005 at T+1..T+2. `wea_out`=1 at T+1 only. `pc`=0x0021 at T+3. `ir_valid` at T+5.
- Wrap: ADD at `pc`=0xFFFF -> `pc`=0x0000. JMP with `reg_in`=0xFFFF -> `pc`=0xFFFF. LD at `pc`=0xFFFE with `offset_in`=2 -> EA 0x0001.
- `fetch_start` during MEM -> ignored, one `ir_valid` only. `rst_n`=0 during MEM with `wea_out` high -> next edge `wea_out`=0, `pc`=0, IDLE. Rerun with RESET_PC=0x3000, MEM_LAT=1 -> `pc`=0x3000, `ir_valid` at T+2.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcode encodings, fetch-controller states and opcode class helpers.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_JMP = 4'b1100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM   = 2'd1,
    FETCH = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_LDR) || (op == OP_STR);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/lc3_next_pc.sv
// Combinational next-PC and effective-address resolution for the retiring instruction.
module lc3_next_pc
  import lc3_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned OFFSET_W = 9
) (
  input  logic [ADDR_W-1:0]          pc,
  input  logic [3:0]                 op_code,
  input  logic signed [OFFSET_W-1:0] offset,
  input  logic [ADDR_W-1:0]          reg_val,
  input  logic [2:0]                 br_nzp,
  input  logic [2:0]                 result_nzp,
  output logic [ADDR_W-1:0]          next_pc,
  output logic [ADDR_W-1:0]          ea
);

  logic [ADDR_W-1:0] sext;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_rel;
  logic              taken;

  // Size cast of a signed operand sign-extends; all sums wrap at ADDR_W.
  assign sext   = ADDR_W'(offset);
  assign pc_inc = pc + ADDR_W'(1);
  assign pc_rel = pc_inc + sext;
  assign taken  = |(br_nzp & result_nzp);

  always_comb begin
    next_pc = pc_inc;
    unique case (op_code)
      OP_BR:   next_pc = taken ? pc_rel : pc_inc;
      OP_JSR:  next_pc = pc_rel;
      OP_JMP:  next_pc = reg_val;
      default: next_pc = pc_inc;
    endcase
  end

  assign ea = ((op_code == OP_LD) || (op_code == OP_ST)) ? pc_rel : (reg_val + sext);

endmodule

// File: rtl/lc3_fetch_ctrl.sv
// LC-3 fetch/redirect controller: optional data access, then instruction fetch on the shared port.
module lc3_fetch_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       OFFSET_W = 9,
  parameter int unsigned       MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_start,
  input  logic [3:0]          opCode_in,
  input  logic [OFFSET_W-1:0] offset_in,
  input  logic [ADDR_W-1:0]   reg_in,
  input  logic [2:0]          br_nzp,
  input  logic [2:0]          result_nzp,
  output logic [ADDR_W-1:0]   addr_out,
  output logic                wea_out,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                ir_valid
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] pc_d, addr_d;
  logic [ADDR_W-1:0] npc_q, npc_d, ea_q, ea_d;
  logic [ADDR_W-1:0] next_pc, ea;
  logic              wea_d, irv_d, last_cycle;

  lc3_next_pc #(
    .ADDR_W  (ADDR_W),
    .OFFSET_W(OFFSET_W)
  ) u_next_pc (
    .pc        (pc),
    .op_code   (opCode_in),
    .offset    (offset_in),
    .reg_val   (reg_in),
    .br_nzp    (br_nzp),
    .result_nzp(result_nzp),
    .next_pc   (next_pc),
    .ea        (ea)
  );

  assign busy       = (state != IDLE);
  assign last_cycle = (cnt == CNT_W'(MEM_LAT));

  // Outputs are computed one cycle ahead so addr_out/wea_out/ir_valid come straight from flops.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pc_d    = pc;
    npc_d   = npc_q;
    ea_d    = ea_q;
    addr_d  = '0;
    wea_d   = 1'b0;
    irv_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fetch_start) begin
          npc_d = next_pc;
          ea_d  = ea;
          cnt_d = CNT_W'(1);
          if (is_mem_op(opCode_in)) begin
            state_d = MEM;
            addr_d  = ea;
            wea_d   = is_store_op(opCode_in);
          end else begin
            state_d = FETCH;
            pc_d    = next_pc;
            addr_d  = next_pc;
          end
        end
      end
      MEM: begin
        if (last_cycle) begin
          state_d = FETCH;
          cnt_d   = CNT_W'(1);
          pc_d    = npc_q;
          addr_d  = npc_q;
        end else begin
          cnt_d  = cnt + CNT_W'(1);
          addr_d = ea_q;
        end
      end
      FETCH: begin
        if (last_cycle) begin
          state_d = IDLE;
          irv_d   = 1'b1;
        end else begin
          cnt_d  = cnt + CNT_W'(1);
          addr_d = npc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pc       <= RESET_PC;
      addr_out <= '0;
      wea_out  <= 1'b0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pc       <= pc_d;
      addr_out <= addr_d;
      wea_out  <= wea_d;
      ir_valid <= irv_d;
    end
  end

  // Captured next-PC and effective address are pure data and need no reset.
  always_ff @(posedge clk) begin
    npc_q <= npc_d;
    ea_q  <= ea_d;
  end

endmodule
